imem_arbiter: RTL and testbench
===============================

IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning instruction memory words.
REQ-002 SHALL have parameter AW, default 10, meaning word-address width, with DEPTH <= 2**AW.
REQ-003 SHALL have port SYS_clk  in  1  single clock; all logic on the rising edge.
REQ-004 SHALL have port SYS_reset  in  1  reset, asynchronous and active-low.
REQ-005 SHALL have port ld_valid  in  1  loader write request.
REQ-006 SHALL have port ld_ready  out  1  loader write accepted this cycle.
REQ-007 SHALL have port ld_addr  in  AW  loader word index.
REQ-008 SHALL have port ld_data  in  32  loader word.
REQ-009 SHALL have port ld_last  in  1  final boot word, qualified by ld_valid.
REQ-010 SHALL have port fetch_req  in  1  CPU fetch request.
REQ-011 SHALL have port fetch_pc  in  32  word index into memory, not a byte address.
REQ-012 SHALL have port fetch_gnt  out  1  fetch issued to memory this cycle.
REQ-013 SHALL have port fetch_valid  out  1  fetch_instr valid.
REQ-014 SHALL have port fetch_instr  out  32  fetched instruction.
REQ-015 SHALL have port cpu_stall  out  1  equal to fetch_req & ~fetch_gnt (combinational).
REQ-016 SHALL have port boot_done  out  1  RUN state reached.
REQ-017 SHALL have memory-side ports mem_en, mem_we (out 1), mem_addr (out AW), mem_wdata (out 32), mem_rdata (in 32); memory is single-port with synchronous read and 1-cycle latency.

Function
REQ-018 SHALL implement FSM states CLEAR, LOAD and RUN.
REQ-019 CLEAR SHALL write 0 to addresses 0..DEPTH-1, one per cycle, then enter LOAD; ld_ready and fetch_gnt SHALL be 0 throughout.
REQ-020 LOAD SHALL assert ld_ready; each ld_valid cycle SHALL write ld_data to ld_addr; fetch_gnt SHALL be 0.
REQ-021 LOAD SHALL transition to RUN the cycle after an accepted ld_last; boot_done SHALL rise with RUN and stay 1 until reset.
REQ-022 RUN SHALL arbitrate the single port between loader (write) and fetch (read) round-robin: on conflict, the requester not granted last conflict wins; first conflict after reset favours fetch.
REQ-023 A request with no competitor SHALL be granted the same cycle.
REQ-024 Losing requester SHALL hold its request; ld_ready=0 or cpu_stall=1 for that cycle.
REQ-025 fetch_valid SHALL pulse 1 cycle after fetch_gnt, with fetch_instr = mem_rdata.
REQ-026 fetch_instr SHALL hold its last value when fetch_valid=0.
REQ-027 fetch_pc >= DEPTH SHALL be granted without mem_en; the next cycle SHALL return fetch_instr = 32'h0000_0013 (NOP) with fetch_valid=1.
REQ-028 ld_addr >= DEPTH SHALL be accepted and discarded, with no mem_we.
REQ-029 Loader write and fetch to the same address in consecutive cycles SHALL return the newly written data.
REQ-030 ld_last in RUN SHALL have no effect on state.

Reset
REQ-031 SYS_reset low SHALL asynchronously force state CLEAR (LOAD if clear disabled), clear counter 0, round-robin pointer to fetch.
REQ-032 Reset SHALL force ld_ready, fetch_gnt, fetch_valid, boot_done, mem_en and mem_we to 0, and fetch_instr, mem_addr and mem_wdata to 0.
REQ-033 Reset asserted mid-CLEAR or mid-LOAD SHALL restart the sequence from the beginning.

Configuration
REQ-034 With macro IMEM_ARBITER_CLEAR_EN defined, the CLEAR state and its counter SHALL be compiled in.
REQ-035 Without IMEM_ARBITER_CLEAR_EN, reset SHALL enter LOAD directly and CLEAR logic SHALL be absent.

Structure
REQ-036 Package imem_pkg SHALL hold the FSM state enum, IMEM_DEPTH, IMEM_AW and NOP_INSTR (32'h0000_0013).
REQ-037 The two-requester round-robin grant SHALL be a sub-module imem_rr_arb.

Verification
REQ-038 DEPTH=16 with CLEAR_EN: release reset -> 16 consecutive mem_we with mem_wdata=0, addresses 0..15, then ld_ready=1.
REQ-039 Load 0x00500093@0 and 0x00100113@1 with ld_last -> boot_done=1; fetch_pc=1 -> fetch_valid next cycle, fetch_instr=0x00100113.
REQ-040 In RUN, fetch_req and ld_valid held high for 4 cycles -> grants alternate fetch, loader, fetch, loader; cpu_stall=1 on the loader cycles.
REQ-041 fetch_pc=20, DEPTH=16 -> no mem_en; next cycle fetch_instr=0x00000013 with fetch_valid=1.
REQ-042 Assert SYS_reset mid-LOAD after 3 writes -> all outputs 0 immediately; after release, CLEAR restarts at address 0.
REQ-043 Write 0xDEADBEEF@5 in RUN, then fetch_pc=5 next cycle -> fetch_instr=0xDEADBEEF.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package imem_pkg;

    localparam int          IMEM_DEPTH = 1024;
    localparam int          IMEM_AW    = 10;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } imem_state_t;

endpackage

// File: rtl/imem_rr_arb.sv
// Two-requester round-robin grant between fetch and loader.
// Latency: combinational grant; priority pointer updates on the clock edge after a conflict.
// Backpressure: the loser of a conflict simply sees no grant and is expected to hold.
module imem_rr_arb (
    input  logic SYS_clk,
    input  logic SYS_reset,
    input  logic arb_en,
    input  logic fetch_req,
    input  logic ld_req,
    output logic fetch_win,
    output logic ld_win
);

    logic fetch_prio_q;
    logic conflict;

    assign conflict = arb_en & fetch_req & ld_req;

    always_comb begin
        fetch_win = 1'b0;
        ld_win    = 1'b0;
        if (conflict) begin
            fetch_win = fetch_prio_q;
            ld_win    = ~fetch_prio_q;
        end else if (arb_en) begin
            fetch_win = fetch_req;
            ld_win    = ld_req;
        end
    end

    // Only conflicts move the pointer; uncontested grants leave fairness untouched.
    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            fetch_prio_q <= 1'b1;
        end else if (conflict) begin
            fetch_prio_q <= ~fetch_prio_q;
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// Instruction memory port owner: optional zero-fill (IMEM_ARBITER_CLEAR_EN), boot load, then loader/fetch sharing.
// Latency: grants are same-cycle; fetch_valid/fetch_instr follow fetch_gnt by one cycle.
// Backpressure: loser holds its request, seeing ld_ready=0 or cpu_stall=1.
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int AW    = IMEM_AW
) (
    input  logic          SYS_clk,
    input  logic          SYS_reset,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [AW-1:0] ld_addr,
    input  logic [31:0]   ld_data,
    input  logic          ld_last,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_pc,
    output logic          fetch_gnt,
    output logic          fetch_valid,
    output logic [31:0]   fetch_instr,
    output logic          cpu_stall,
    output logic          boot_done,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata
);

    localparam logic [31:0] DEPTH_PC = 32'(DEPTH);
    localparam logic [AW:0] DEPTH_LD = (AW+1)'(DEPTH);

    imem_state_t   state_q;
    imem_state_t   state_nxt;

    logic          ld_in_range;
    logic          pc_in_range;
    logic          arb_en;
    logic          arb_fetch_win;
    logic          arb_ld_win;

    logic          ld_ready_c;
    logic          fetch_gnt_c;
    logic          mem_en_c;
    logic          mem_we_c;
    logic [AW-1:0] mem_addr_c;
    logic [31:0]   mem_wdata_c;

    logic          fetch_valid_q;
    logic          fetch_oor_q;
    logic [31:0]   instr_q;

    assign ld_in_range = ({1'b0, ld_addr} < DEPTH_LD);
    assign pc_in_range = (fetch_pc < DEPTH_PC);
    assign arb_en      = (state_q == ST_RUN);

`ifdef IMEM_ARBITER_CLEAR_EN
    localparam imem_state_t RESET_STATE = ST_CLEAR;

    logic [AW-1:0] clr_cnt_q;
    logic          clr_last;

    assign clr_last = (clr_cnt_q == AW'(DEPTH - 1));

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            clr_cnt_q <= '0;
        end else if (state_q == ST_CLEAR) begin
            clr_cnt_q <= clr_last ? '0 : clr_cnt_q + AW'(1);
        end
    end
`else
    localparam imem_state_t RESET_STATE = ST_LOAD;
`endif

    imem_rr_arb u_rr_arb (
        .SYS_clk   (SYS_clk),
        .SYS_reset (SYS_reset),
        .arb_en    (arb_en),
        .fetch_req (fetch_req),
        .ld_req    (ld_valid),
        .fetch_win (arb_fetch_win),
        .ld_win    (arb_ld_win)
    );

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            state_q <= RESET_STATE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        ld_ready_c  = 1'b0;
        fetch_gnt_c = 1'b0;
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        case (state_q)
`ifdef IMEM_ARBITER_CLEAR_EN
            ST_CLEAR: begin
                mem_en_c   = 1'b1;
                mem_we_c   = 1'b1;
                mem_addr_c = clr_cnt_q;
                if (clr_last) begin
                    state_nxt = ST_LOAD;
                end
            end
`endif
            ST_LOAD: begin
                ld_ready_c = 1'b1;
                if (ld_valid) begin
                    // Out-of-range words are acknowledged but never reach the array.
                    mem_en_c    = ld_in_range;
                    mem_we_c    = ld_in_range;
                    mem_addr_c  = ld_addr;
                    mem_wdata_c = ld_data;
                    if (ld_last) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (arb_ld_win) begin
                    ld_ready_c  = 1'b1;
                    mem_en_c    = ld_in_range;
                    mem_we_c    = ld_in_range;
                    mem_addr_c  = ld_addr;
                    mem_wdata_c = ld_data;
                end else if (arb_fetch_win) begin
                    fetch_gnt_c = 1'b1;
                    mem_en_c    = pc_in_range;
                    mem_addr_c  = fetch_pc[AW-1:0];
                end
            end
            default: begin
                state_nxt = RESET_STATE;
            end
        endcase
    end

    // Port controls are decoded from state, so reset must mask them to read as idle immediately.
    assign ld_ready  = SYS_reset & ld_ready_c;
    assign fetch_gnt = SYS_reset & fetch_gnt_c;
    assign mem_en    = SYS_reset & mem_en_c;
    assign mem_we    = SYS_reset & mem_we_c;
    assign mem_addr  = SYS_reset ? mem_addr_c  : '0;
    assign mem_wdata = SYS_reset ? mem_wdata_c : '0;
    assign cpu_stall = fetch_req & ~fetch_gnt;
    assign boot_done = (state_q == ST_RUN);

    always_ff @(posedge SYS_clk or negedge SYS_reset) begin
        if (!SYS_reset) begin
            fetch_valid_q <= 1'b0;
            fetch_oor_q   <= 1'b0;
            instr_q       <= '0;
        end else begin
            fetch_valid_q <= fetch_gnt;
            if (fetch_gnt) begin
                fetch_oor_q <= ~pc_in_range;
            end
            if (fetch_valid_q) begin
                instr_q <= fetch_instr;
            end
        end
    end

    // Read data is live only in the response cycle; instr_q keeps it visible afterwards.
    assign fetch_valid = fetch_valid_q;
    assign fetch_instr = fetch_valid_q ? (fetch_oor_q ? NOP_INSTR : mem_rdata) : instr_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Bench for imem_arbiter at DEPTH=16, AW=5 with a behavioural memory and reference model.
module tb_imem_arbiter;
    import imem_pkg::*;

    localparam int DEPTH = 16;
    localparam int AW    = 5;

    logic          SYS_clk = 1'b0;
    logic          SYS_reset;
    logic          ld_valid;
    logic          ld_ready;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_data;
    logic          ld_last;
    logic          fetch_req;
    logic [31:0]   fetch_pc;
    logic          fetch_gnt;
    logic          fetch_valid;
    logic [31:0]   fetch_instr;
    logic          cpu_stall;
    logic          boot_done;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;

    logic          preload;
    logic [31:0]   tb_mem  [2**AW];
    logic [31:0]   exp_mem [2**AW];
    bit            exp_fv;
    logic [31:0]   exp_instr;
    bit            fetch_won_last;
    int            total = 0;
    int            bad   = 0;

    always #5 SYS_clk = ~SYS_clk;

    imem_arbiter #(.DEPTH(DEPTH), .AW(AW)) dut (
        .SYS_clk     (SYS_clk),
        .SYS_reset   (SYS_reset),
        .ld_valid    (ld_valid),
        .ld_ready    (ld_ready),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_last     (ld_last),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .fetch_gnt   (fetch_gnt),
        .fetch_valid (fetch_valid),
        .fetch_instr (fetch_instr),
        .cpu_stall   (cpu_stall),
        .boot_done   (boot_done),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    // Single-port synchronous RAM, one-cycle read latency.
    always @(posedge SYS_clk) begin
        if (preload) begin
            for (int i = 0; i < 2**AW; i++) tb_mem[i] <= 32'hA5A5_0000 + 32'(i);
        end else if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit fr, input logic [31:0] pc, input bit lv,
                         input logic [AW-1:0] la, input logic [31:0] ld, input bit ll);
        fetch_req = fr;
        fetch_pc  = pc;
        ld_valid  = lv;
        ld_addr   = la;
        ld_data   = ld;
        ld_last   = ll;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ld_ready"},    32'(ld_ready),    32'd0);
        chk({tag, "_fetch_gnt"},   32'(fetch_gnt),   32'd0);
        chk({tag, "_fetch_valid"}, 32'(fetch_valid), 32'd0);
        chk({tag, "_boot_done"},   32'(boot_done),   32'd0);
        chk({tag, "_mem_en"},      32'(mem_en),      32'd0);
        chk({tag, "_mem_we"},      32'(mem_we),      32'd0);
        chk({tag, "_fetch_instr"}, fetch_instr,      32'd0);
        chk({tag, "_mem_addr"},    32'(mem_addr),    32'd0);
        chk({tag, "_mem_wdata"},   mem_wdata,        32'd0);
    endtask

    // Called at posedge+1 right after reset release; checks the full zero-fill pass.
    task automatic check_clear();
        drive(1'b1, 32'd0, 1'b1, '0, 32'hFFFF_FFFF, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            chk("clr_en",    32'(mem_en),    32'd1);
            chk("clr_we",    32'(mem_we),    32'd1);
            chk("clr_addr",  32'(mem_addr),  32'(i));
            chk("clr_wdata", mem_wdata,      32'd0);
            chk("clr_ready", 32'(ld_ready),  32'd0);
            chk("clr_gnt",   32'(fetch_gnt), 32'd0);
            @(posedge SYS_clk); #1;
        end
        for (int i = 0; i < 2**AW; i++) if (i < DEPTH) exp_mem[i] = 32'd0;
    endtask

    task automatic tick_load(input bit lv, input logic [AW-1:0] la, input logic [31:0] ld, input bit ll);
        bit wr;
        wr = lv && (la < DEPTH);
        drive(1'b1, 32'd0, lv, la, ld, ll);
        #1;
        chk("load_ready", 32'(ld_ready),    32'd1);
        chk("load_gnt",   32'(fetch_gnt),   32'd0);
        chk("load_stall", 32'(cpu_stall),   32'd1);
        chk("load_boot",  32'(boot_done),   32'd0);
        chk("load_fv",    32'(fetch_valid), 32'd0);
        chk("load_we",    32'(mem_we),      32'(wr));
        chk("load_en",    32'(mem_en),      32'(wr));
        if (wr) begin
            chk("load_addr",  32'(mem_addr), 32'(la));
            chk("load_wdata", mem_wdata,     ld);
            exp_mem[la] = ld;
        end
        @(posedge SYS_clk); #1;
    endtask

    task automatic tick_run(input bit fr, input logic [31:0] pc, input bit lv,
                            input logic [AW-1:0] la, input logic [31:0] ld, input bit ll,
                            output bit m_f, output bit m_l, output bit o_f);
        bit            en_e;
        bit            we_e;
        logic [AW-1:0] addr_e;
        drive(fr, pc, lv, la, ld, ll);
        #1;
        chk("run_fv",    32'(fetch_valid), 32'(exp_fv));
        chk("run_instr", fetch_instr,      exp_instr);
        chk("run_boot",  32'(boot_done),   32'd1);
        // Contention goes to whoever did not win the previous contention.
        m_f = fr && (!lv || !fetch_won_last);
        m_l = lv && !m_f;
        if (fr && lv) fetch_won_last = m_f;
        o_f    = fetch_gnt;
        we_e   = m_l && (la < DEPTH);
        en_e   = we_e || (m_f && (pc < DEPTH));
        addr_e = m_f ? pc[AW-1:0] : la;
        chk("run_gnt",   32'(fetch_gnt), 32'(m_f));
        chk("run_ready", 32'(ld_ready),  32'(m_l));
        chk("run_stall", 32'(cpu_stall), 32'(fr && !m_f));
        chk("run_en",    32'(mem_en),    32'(en_e));
        chk("run_we",    32'(mem_we),    32'(we_e));
        if (en_e) chk("run_addr", 32'(mem_addr), 32'(addr_e));
        if (we_e) begin
            chk("run_wdata", mem_wdata, ld);
            exp_mem[la] = ld;
        end
        if (m_f) exp_instr = (pc < DEPTH) ? exp_mem[pc[AW-1:0]] : NOP_INSTR;
        exp_fv = m_f;
        @(posedge SYS_clk); #1;
    endtask

    initial begin
        bit            d_f, d_l, d_o;
        logic [3:0]    pat;
        bit            pf, pl, rll;
        logic [31:0]   rpc, rld;
        logic [AW-1:0] rla;

        SYS_reset      = 1'b0;
        preload        = 1'b1;
        exp_fv         = 1'b0;
        exp_instr      = 32'd0;
        fetch_won_last = 1'b0;
        pf             = 1'b0;
        pl             = 1'b0;
        rpc            = '0;
        rla            = '0;
        rld            = '0;
        rll            = 1'b0;
        pat            = '0;
        drive(1'b0, 32'd0, 1'b0, '0, 32'd0, 1'b0);
        for (int i = 0; i < 2**AW; i++) exp_mem[i] = 32'hA5A5_0000 + 32'(i);
        repeat (2) @(posedge SYS_clk);
        #1;
        chk_reset_outputs("rst0");
        preload   = 1'b0;
        SYS_reset = 1'b1;
`ifdef IMEM_ARBITER_CLEAR_EN
        check_clear();
`endif

        // Three boot words, then reset lands in the middle of the cycle.
        tick_load(1'b1, 5'd3, 32'h3333_3333, 1'b0);
        tick_load(1'b1, 5'd4, 32'h4444_4444, 1'b0);
        tick_load(1'b1, 5'd5, 32'h5555_5555, 1'b0);
        drive(1'b1, 32'd0, 1'b1, 5'd6, 32'h6666_6666, 1'b1);
        #2;
        SYS_reset = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(posedge SYS_clk); #1;
        SYS_reset = 1'b1;
`ifdef IMEM_ARBITER_CLEAR_EN
        check_clear();
`endif

        tick_load(1'b1, 5'd0,  32'h0050_0093, 1'b0);
        tick_load(1'b1, 5'd20, 32'hBAD0_BAD0, 1'b0);
        tick_load(1'b0, 5'd7,  32'h7777_7777, 1'b0);
        tick_load(1'b1, 5'd1,  32'h0010_0113, 1'b1);

        tick_run(1'b1, 32'd1, 1'b0, '0, 32'd0, 1'b0, d_f, d_l, d_o);
        tick_run(1'b0, 32'd0, 1'b0, '0, 32'd0, 1'b0, d_f, d_l, d_o);
        chk("boot_fetch_hold", fetch_instr, 32'h0010_0113);

        for (int i = 0; i < 4; i++) begin
            tick_run(1'b1, 32'd0, 1'b1, 5'd8, 32'h1111_2222, 1'b0, d_f, d_l, d_o);
            pat[3-i] = d_o;
        end
        chk("rr_alternate", 32'(pat), 32'(4'b1010));

        tick_run(1'b0, 32'd0, 1'b1, 5'd9, 32'h0000_ABCD, 1'b1, d_f, d_l, d_o);
        tick_run(1'b1, 32'd20, 1'b0, '0, 32'd0, 1'b0, d_f, d_l, d_o);
        tick_run(1'b0, 32'd0, 1'b0, '0, 32'd0, 1'b0, d_f, d_l, d_o);
        chk("oor_nop_hold", fetch_instr, 32'h0000_0013);

        tick_run(1'b0, 32'd0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, d_f, d_l, d_o);
        tick_run(1'b1, 32'd5, 1'b0, '0, 32'd0, 1'b0, d_f, d_l, d_o);
        tick_run(1'b0, 32'd0, 1'b0, '0, 32'd0, 1'b0, d_f, d_l, d_o);
        chk("wr_then_fetch", fetch_instr, 32'hDEAD_BEEF);

        // Random traffic; a losing requester keeps presenting the same request.
        for (int c = 0; c < 400; c++) begin
            if (!pf && $urandom_range(0, 2) != 0) begin
                pf  = 1'b1;
                rpc = 32'($urandom_range(0, 19));
            end
            if (!pl && $urandom_range(0, 2) != 0) begin
                pl  = 1'b1;
                rla = AW'($urandom_range(0, 19));
                rld = $urandom;
                rll = 1'($urandom_range(0, 1));
            end
            tick_run(pf, rpc, pl, rla, rld, rll, d_f, d_l, d_o);
            if (d_f) pf = 1'b0;
            if (d_l) pl = 1'b0;
        end
        tick_run(1'b0, 32'd0, 1'b0, '0, 32'd0, 1'b0, d_f, d_l, d_o);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
